run_sequencer: RTL
==================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter D, default 12, SHALL set cycle-counter and result width in bits.
REQ-002 Parameter A, default 3, SHALL set program-index width; NPROG = 2**A program slots.
REQ-003 Parameter TIMEOUT, default 1000, SHALL set the watchdog limit in cycles; valid range 1 to 2**D-1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-006 start  input  1  SHALL be a one-cycle request to run every program selected in prog_mask.
REQ-007 prog_mask  input  NPROG  SHALL select programs; bit i set means run program i.
REQ-008 cpu_req  output  1  SHALL be the one-cycle launch pulse to the processor core.
REQ-009 cpu_sel  output  A  SHALL give the index of the program being launched or run.
REQ-010 cpu_done  input  1  SHALL be the core's completion indication.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 all_done  output  1  SHALL be a one-cycle pulse when the batch finishes.
REQ-013 rd_idx  input  A  SHALL give the result-table read address.
REQ-014 rd_cycles  output  D  SHALL give the stored cycle count for rd_idx, combinational read.
REQ-015 rd_tmo  output  1  SHALL give the stored timeout flag for rd_idx, combinational read.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT, NEXT and DONE.
REQ-017 In IDLE with start=1 and prog_mask nonzero, the block SHALL latch the mask, set idx to the lowest set bit, and go to REQ.
REQ-018 In IDLE with start=1 and prog_mask=0, the block SHALL go to DONE without touching the result table.
REQ-019 In REQ, the block SHALL drive cpu_req=1 and cpu_sel=idx for exactly one cycle, clear the counter to 0, then go to WAIT.
REQ-020 cpu_done SHALL be ignored in every state except WAIT.
REQ-021 In WAIT, the counter SHALL increment by 1 each cycle, so the first WAIT cycle yields count 1.
REQ-022 In a WAIT cycle with cpu_done=1, the block SHALL write the counter value including that cycle to cycles[idx], clear tmo[idx], and go to NEXT.
REQ-023 The counter SHALL saturate at 2**D-1 and never wrap.
REQ-024 In NEXT, the block SHALL move idx to the next set mask bit above idx and go to REQ; if no such bit exists it SHALL go to DONE.
REQ-025 In DONE, the block SHALL assert all_done for one cycle and return to IDLE.
REQ-026 start SHALL be ignored while busy=1; the latched mask SHALL NOT change during a batch.
REQ-027 Result entries for unselected programs SHALL retain their previous values.
REQ-028 cpu_sel SHALL hold idx in REQ and WAIT and SHALL be 0 in all other states.

Reset
REQ-029 With reset=0 at a clock edge, the block SHALL go to IDLE and drive cpu_req=0, cpu_sel=0, busy=0, all_done=0; the counter, idx, latched mask, all cycles[] and all tmo[] SHALL clear to 0.
REQ-030 Reset mid-batch SHALL abort the batch immediately, with no all_done pulse and no result write in that cycle.

Configuration
REQ-031 With RUN_SEQ_TIMEOUT_EN defined, a WAIT cycle in which the counter reaches TIMEOUT and cpu_done=0 SHALL write TIMEOUT to cycles[idx], set tmo[idx]=1, and go to NEXT.
REQ-032 With RUN_SEQ_TIMEOUT_EN defined, cpu_done=1 in that same cycle SHALL take priority and be recorded as a normal completion with tmo[idx]=0.
REQ-033 Without RUN_SEQ_TIMEOUT_EN, WAIT SHALL last until cpu_done=1, the counter SHALL still saturate, and tmo[] SHALL always read 0.

Verification
REQ-034 Single program: reset, start with prog_mask=8'h01, cpu_done asserted 5 cycles after cpu_req -> one cpu_req with cpu_sel=0, rd_cycles[0]=5, rd_tmo[0]=0, one all_done pulse.
REQ-035 Sparse mask: prog_mask=8'hA4 -> cpu_req pulses with cpu_sel 2, 5, 7 in order; all_done one cycle after the NEXT following program 7; entries 0, 1, 3, 4, 6 unchanged.
REQ-036 Empty mask: start with prog_mask=0 -> busy high for one cycle (DONE), all_done pulse, cpu_req never asserted.
REQ-037 Timeout: macro defined, TIMEOUT=16, cpu_done never asserted for program 3 -> rd_cycles[3]=16, rd_tmo[3]=1, batch continues; macro undefined -> block stays in WAIT with busy=1.
REQ-038 Noise and reset: start pulsed during WAIT and cpu_done pulsed in IDLE and REQ -> no effect; reset=0 during WAIT of the second program -> IDLE next edge, all outputs and table zero, no all_done.

Source files
------------

// File: rtl/run_sequencer.sv
// Batch program sequencer: launches each selected program on the core in index order,
// times it, and keeps a per-program cycle-count / timeout table. Optional watchdog: RUN_SEQ_TIMEOUT_EN.
module run_sequencer #(
    parameter int D       = 12,
    parameter int A       = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2**A-1:0]   prog_mask,
    output logic              cpu_req,
    output logic [A-1:0]      cpu_sel,
    input  logic              cpu_done,
    output logic              busy,
    output logic              all_done,
    input  logic [A-1:0]      rd_idx,
    output logic [D-1:0]      rd_cycles,
    output logic              rd_tmo
);

    localparam int NPROG = 2**A;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NPROG-1:0]   r_mask;
    logic [A-1:0]       r_idx;
    logic [D-1:0]       r_cnt;
    logic [D-1:0]       r_cycles [NPROG];
    logic               r_tmo    [NPROG];

    logic [A:0]         w_first;
    logic [A:0]         w_next;
    logic [D-1:0]       w_cnt_nxt;
    logic               w_timeout;

    // Lowest set bit of m at or above lo; MSB of the result flags "found".
    function automatic logic [A:0] first_from(input logic [NPROG-1:0] m, input int lo);
        logic [A:0] r;
        r = '0;
        for (int i = NPROG - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) r = {1'b1, A'(i)};
        end
        return r;
    endfunction

    assign w_first   = first_from(prog_mask, 0);
    assign w_next    = first_from(r_mask, int'(r_idx) + 1);
    assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam logic [D-1:0] TMO_LIM = D'(TIMEOUT);
    assign w_timeout = (w_cnt_nxt == TMO_LIM);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_first[A] ? S_REQ : S_DONE;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  if (cpu_done || w_timeout) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = w_next[A] ? S_REQ : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_req  = (r_state == S_REQ);
        cpu_sel  = (r_state == S_REQ || r_state == S_WAIT) ? r_idx : '0;
        busy     = (r_state != S_IDLE);
        all_done = (r_state == S_DONE);
    end

    // A completion on the watchdog cycle wins and is recorded as a normal finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mask <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < NPROG; i++) begin
                r_cycles[i] <= '0;
                r_tmo[i]    <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (start && w_first[A]) begin
                    r_mask <= prog_mask;
                    r_idx  <= w_first[A-1:0];
                end
                S_REQ:  r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    if (cpu_done) begin
                        r_cycles[r_idx] <= w_cnt_nxt;
                        r_tmo[r_idx]    <= 1'b0;
                    end else if (w_timeout) begin
                        r_cycles[r_idx] <= w_cnt_nxt;
                        r_tmo[r_idx]    <= 1'b1;
                    end
                end
                S_NEXT: if (w_next[A]) r_idx <= w_next[A-1:0];
                default: ;
            endcase
        end
    end

    assign rd_cycles = r_cycles[rd_idx];
    assign rd_tmo    = r_tmo[rd_idx];

endmodule
